imem_pair_server: RTL and testbench

//  Instruction-memory responder for the dual-issue core's fetch interface.

---
 rtl/imem_pair_server.sv | 103 ++++++++++
 tb/tb_imem_pair_server.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/imem_pair_server.sv
// Dual-issue instruction memory: even/odd word banks return {word[a+1], word[a]} in one cycle.
// A boot loader FSM fills the banks sequentially before the core is allowed to fetch.
module imem_pair_server #(
  parameter int          AW        = 10,
  parameter logic [31:0] NOP       = 32'h00000013,
  parameter bit          BOOT_LOAD = 1'b1
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic [AW-1:0] addr_i,
  input  logic          fetch_en_i,
  output logic [63:0]   data_o,
  input  logic          load_start_i,
  input  logic          load_valid_i,
  input  logic [31:0]   load_data_i,
  input  logic          load_last_i,
  output logic          load_ready_o,
  output logic          boot_done_o
);

  localparam int RW   = AW - 1;
  localparam int ROWS = 1 << RW;

  typedef enum logic {LOAD, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [63:0]   data_q, data_d;
  logic          boot_done_q, boot_done_d;
  logic          wr_en;

  logic [31:0]   mem_even [ROWS];
  logic [31:0]   mem_odd  [ROWS];

  logic [RW-1:0] row_hi, row_even;
  logic [31:0]   rd_even, rd_odd;
  logic [63:0]   packet;

  // An odd start address needs the even word from the next row up.
  always_comb begin
    row_hi   = addr_i[AW-1:1];
    row_even = addr_i[0] ? row_hi + RW'(1) : row_hi;
    rd_even  = mem_even[row_even];
    rd_odd   = mem_odd[row_hi];
    packet   = addr_i[0] ? {rd_even, rd_odd} : {rd_odd, rd_even};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wr_en   = 1'b0;
    case (state_q)
      LOAD: begin
        if (fetch_en_i) data_d = {NOP, NOP};
        if (load_valid_i) begin
          wr_en = 1'b1;
          if (load_last_i || (cnt_q == {AW{1'b1}})) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: begin
        if (fetch_en_i) data_d = packet;
        if (load_start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
    endcase
    boot_done_d = (state_d == RUN);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= BOOT_LOAD ? LOAD : RUN;
      cnt_q       <= '0;
      data_q      <= {NOP, NOP};
      boot_done_q <= !BOOT_LOAD;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      boot_done_q <= boot_done_d;
    end
  end

  // Memory contents survive reset so a warm reset does not require a reload.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      if (cnt_q[0]) mem_odd[cnt_q[AW-1:1]]  <= load_data_i;
      else          mem_even[cnt_q[AW-1:1]] <= load_data_i;
    end
  end

  assign data_o       = data_q;
  assign load_ready_o = (state_q == LOAD);
  assign boot_done_o  = boot_done_q;

endmodule

// File: tb/tb_imem_pair_server.sv
// Directed bench for imem_pair_server: boot load, paired fetch, stall hold, reset mid-load, full-depth load.
module tb_imem_pair_server;

  localparam logic [63:0] NOPS = 64'h00000013_00000013;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic [9:0]  addr_i;
  logic        fetch_en_i;
  logic [63:0] data_o;
  logic        load_start_i;
  logic        load_valid_i;
  logic [31:0] load_data_i;
  logic        load_last_i;
  logic        load_ready_o;
  logic        boot_done_o;

  int n_cmp = 0;
  int n_err = 0;

  imem_pair_server dut (
    .clock_i      (clock_i),
    .reset_n_i    (reset_n_i),
    .addr_i       (addr_i),
    .fetch_en_i   (fetch_en_i),
    .data_o       (data_o),
    .load_start_i (load_start_i),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_last_i  (load_last_i),
    .load_ready_o (load_ready_o),
    .boot_done_o  (boot_done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid_i = 1'b1;
    load_data_i  = d;
    load_last_i  = last;
    tick();
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
  endtask

  task automatic fetch(input logic [9:0] a);
    addr_i     = a;
    fetch_en_i = 1'b1;
    tick();
  endtask

  initial begin
    reset_n_i    = 1'b0;
    addr_i       = '0;
    fetch_en_i   = 1'b1;
    load_start_i = 1'b0;
    load_valid_i = 1'b0;
    load_data_i  = '0;
    load_last_i  = 1'b0;
    #12;
    check_eq("rst_data",  data_o, NOPS);
    check_eq("rst_ready", {63'd0, load_ready_o}, 64'd1);
    check_eq("rst_done",  {63'd0, boot_done_o}, 64'd0);
    reset_n_i = 1'b1;
    tick();

    // Gapped boot load of four words, last flag on the fourth.
    for (int i = 0; i < 4; i++) begin
      load_word(32'h11 * (i + 1), i == 3);
      if (i < 3) begin
        check_eq("gap_ready", {63'd0, load_ready_o}, 64'd1);
        tick();
      end
    end
    check_eq("boot_done",   {63'd0, boot_done_o}, 64'd1);
    check_eq("boot_ready",  {63'd0, load_ready_o}, 64'd0);
    check_eq("leave_nop",   data_o, NOPS);

    fetch(10'd0); check_eq("fetch0", data_o, 64'h00000022_00000011);
    fetch(10'd1); check_eq("fetch1", data_o, 64'h00000033_00000022);
    fetch(10'd2); check_eq("fetch2", data_o, 64'h00000044_00000033);

    // Stall: data must hold while the address wanders.
    fetch_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_i = 10'(i);
      tick();
      check_eq("hold", data_o, 64'h00000044_00000033);
    end
    fetch(10'd0); check_eq("reenable", data_o, 64'h00000022_00000011);

    // Re-enter LOAD; the requesting edge still fetches.
    load_start_i = 1'b1;
    fetch(10'd1);
    load_start_i = 1'b0;
    check_eq("start_fetch", data_o, 64'h00000033_00000022);
    check_eq("start_ready", {63'd0, load_ready_o}, 64'd1);
    check_eq("start_done",  {63'd0, boot_done_o}, 64'd0);
    fetch(10'd1); check_eq("load_nop", data_o, NOPS);

    // Reset after two words, then reload from word 0.
    load_word(32'h55, 1'b0);
    load_word(32'h66, 1'b0);
    reset_n_i = 1'b0;
    #2;
    check_eq("mid_rst_data",  data_o, NOPS);
    check_eq("mid_rst_ready", {63'd0, load_ready_o}, 64'd1);
    check_eq("mid_rst_done",  {63'd0, boot_done_o}, 64'd0);
    reset_n_i = 1'b1;
    tick();
    load_word(32'h77, 1'b0);
    load_word(32'h88, 1'b1);
    check_eq("reload_done", {63'd0, boot_done_o}, 64'd1);
    fetch(10'd0); check_eq("reload_w01", data_o, 64'h00000088_00000077);
    fetch(10'd2); check_eq("keep_w23",   data_o, 64'h00000044_00000033);

    // Full-depth load with no last flag; word 1023 forces the exit.
    load_start_i = 1'b1;
    fetch_en_i   = 1'b0;
    tick();
    load_start_i = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (i == 1023) check_eq("full_ready", {63'd0, load_ready_o}, 64'd1);
      load_valid_i = 1'b1;
      load_data_i  = (i == 1023) ? 32'hAA : 32'(i);
      load_last_i  = 1'b0;
      tick();
    end
    load_valid_i = 1'b0;
    check_eq("full_done",  {63'd0, boot_done_o}, 64'd1);
    check_eq("full_ready_lo", {63'd0, load_ready_o}, 64'd0);
    fetch(10'd1023); check_eq("wrap1023", data_o, 64'h00000000_000000AA);
    fetch(10'd1022); check_eq("fetch1022", data_o, 64'h000000AA_000003FE);
    fetch(10'd1);    check_eq("fetch1_full", data_o, 64'h00000002_00000001);
    fetch(10'd514);  check_eq("fetch514", data_o, 64'h00000203_00000202);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
